// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time program loader. Packs a byte stream (valid/ready)
//               into 32-bit little-endian words, writes them sequentially to
//               the core's instruction memory, and holds the core in reset
//               (active-low core_rst) until the requested word count has been
//               written.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   load_words,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            checksum
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // DEPTH = 2**ADDR_WIDTH, expressed in the (ADDR_WIDTH+1)-bit count width
    localparam logic [ADDR_WIDTH:0] c_DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_CNT_ZERO = '0;
    localparam logic [ADDR_WIDTH:0] c_CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [1:0]            w_next;

    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_word_idx;
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_asm;

    logic                  r_byte_ready;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_core_rst;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [7:0]            r_checksum;

    // ------------------------------------------------------------------------
    // Decodes
    // ------------------------------------------------------------------------
    logic                  w_count_ok;
    logic                  w_can_start;
    logic                  w_start_ok;
    logic                  w_start_bad;
    logic                  w_accept;
    logic                  w_last_byte;
    logic [ADDR_WIDTH:0]   w_word_idx_inc;
    logic                  w_last_word;

    // A count is usable only if it is non-zero and fits the memory
    assign w_count_ok     = (load_words != c_CNT_ZERO) && (load_words <= c_DEPTH);
    // start is only honoured while no load is in flight
    assign w_can_start    = (r_state == c_IDLE) || (r_state == c_DONE);
    assign w_start_ok     = w_can_start && start &&  w_count_ok;
    assign w_start_bad    = w_can_start && start && !w_count_ok;
    // byte_ready is high only in LOAD, so this also gates byte_valid by state
    assign w_accept       = (r_state == c_LOAD) && byte_valid && r_byte_ready;
    assign w_last_byte    = (r_byte_idx == 2'd3);
    assign w_word_idx_inc = r_word_idx + c_CNT_ONE;
    assign w_last_word    = (w_word_idx_inc == r_count);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start_ok) begin
                    w_next = c_LOAD;
                end
            end
            c_LOAD: begin
                if (w_accept && w_last_byte) begin
                    w_next = c_WRITE;
                end
            end
            c_WRITE: begin
                w_next = w_last_word ? c_DONE : c_LOAD;
            end
            c_DONE: begin
                if (w_start_ok) begin
                    w_next = c_LOAD;
                end
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // Control outputs registered from the next state so they line up with it;
    // core_rst only rises on entry to DONE, i.e. after the final write cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_busy       <= 1'b0;
            r_core_rst   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_byte_ready <= (w_next == c_LOAD);
            r_mem_we     <= (w_next == c_WRITE);
            r_busy       <= (w_next == c_LOAD) || (w_next == c_WRITE);
            r_core_rst   <= (w_next == c_DONE);
            r_done       <= (w_next == c_DONE);
        end
    end

    // Error flag: set by a rejected start, cleared by an accepted one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if (w_start_bad) begin
            r_err <= 1'b1;
        end
    end

    // Load bookkeeping: word count, word index, byte index and running checksum
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_checksum <= 8'h00;
        end else if (w_start_ok) begin
            r_count    <= load_words;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_checksum <= 8'h00;
        end else begin
            if (w_accept) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                r_checksum <= r_checksum ^ byte_data;
            end
            if (r_state == c_WRITE) begin
                r_word_idx <= w_word_idx_inc;
            end
        end
    end

    // Word assembly: bytes 0..2 collect in r_asm; byte 3 completes the word
    // and captures the write address so both hold steady through WRITE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm       <= 24'h0;
            r_mem_wdata <= 32'h0;
            r_mem_addr  <= '0;
        end else if (w_start_ok) begin
            r_mem_addr  <= '0;
        end else if (w_accept) begin
            case (r_byte_idx)
                2'd0: r_asm[7:0]   <= byte_data;
                2'd1: r_asm[15:8]  <= byte_data;
                2'd2: r_asm[23:16] <= byte_data;
                default: begin
                    r_mem_wdata <= {byte_data, r_asm};
                    r_mem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign byte_ready = r_byte_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign core_rst   = r_core_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign checksum   = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader (ADDR_WIDTH=2, DEPTH=4).
//               Cycle-by-cycle vector table plus directed multi-cycle
//               sequences for stalls, mid-load reset, reload and full depth.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   load_words;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [7:0]    checksum;

    int n_vec  = 0;
    int n_miss = 0;

    logic [AW+31:0] wlog[$];
    int             crst_during_write = 0;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_words (load_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Write log sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we) begin
            wlog.push_back({mem_addr, mem_wdata});
            if (core_rst) crst_during_write++;
        end
    end

    typedef struct {
        logic          rst;
        logic          start;
        logic [AW:0]   lw;
        logic          bv;
        logic [7:0]    bd;
        logic          br;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic          cr;
        logic          busy;
        logic          done;
        logic          err;
        logic [7:0]    cs;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(logic r, logic s, logic [AW:0] lw, logic bv, logic [7:0] bd,
                               logic br, logic we, logic [AW-1:0] a, logic [31:0] wd,
                               logic cr, logic bz, logic dn, logic er, logic [7:0] cs);
        vec_t x;
        x.rst = r;  x.start = s; x.lw = lw; x.bv = bv; x.bd = bd;
        x.br = br;  x.we = we;   x.addr = a; x.wd = wd;
        x.cr = cr;  x.busy = bz; x.done = dn; x.err = er; x.cs = cs;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; start = 1'b0; load_words = '0; byte_valid = 1'b0; byte_data = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [AW:0] n);
        start = 1'b1; load_words = n;
        tick();
        start = 1'b0; load_words = '0;
    endtask

    // Offer one byte until accepted (bounded), then idle for 'stall' cycles
    task automatic send_byte(input logic [7:0] b, input int stall);
        logic rdy;
        int   t;
        byte_valid = 1'b1; byte_data = b;
        t = 0;
        do begin
            rdy = byte_ready;
            tick();
            t++;
        end while (!rdy && t < 20);
        if (!rdy) begin
            n_vec++; n_miss++;
            $display("FAIL byte_accept_timeout: got no ready expected ready for byte %h", b);
        end
        byte_valid = 1'b0; byte_data = 8'h00;
        repeat (stall) tick();
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 60 && !done; i++) tick();
        chk(nm, {63'd0, done}, 64'd1);
    endtask

    logic [7:0] bytes8 [0:7];

    initial begin
        idle_inputs();

        // ---------------- table: 2-word load, errors, priority ----------------
        //          rst st lw bv bd      br we a  wd             cr bz dn er cs
        vt.push_back(v(1,0,0,0,8'h00,  0,0,0,32'h0,        0,0,0,0,8'h00));
        vt.push_back(v(0,1,2,0,8'h00,  1,0,0,32'h0,        0,1,0,0,8'h00));
        vt.push_back(v(0,0,0,1,8'h13,  1,0,0,32'h0,        0,1,0,0,8'h13));
        vt.push_back(v(0,1,0,1,8'h00,  1,0,0,32'h0,        0,1,0,0,8'h13));
        vt.push_back(v(0,0,0,1,8'h00,  1,0,0,32'h0,        0,1,0,0,8'h13));
        vt.push_back(v(0,0,0,1,8'h00,  0,1,0,32'h00000013, 0,1,0,0,8'h13));
        vt.push_back(v(0,1,1,1,8'hFF,  1,0,0,32'h00000013, 0,1,0,0,8'h13));
        vt.push_back(v(0,0,0,1,8'hB3,  1,0,0,32'h00000013, 0,1,0,0,8'hA0));
        vt.push_back(v(0,0,0,1,8'h00,  1,0,0,32'h00000013, 0,1,0,0,8'hA0));
        vt.push_back(v(0,0,0,1,8'h10,  1,0,0,32'h00000013, 0,1,0,0,8'hB0));
        vt.push_back(v(0,0,0,1,8'h00,  0,1,1,32'h001000B3, 0,1,0,0,8'hB0));
        vt.push_back(v(0,0,0,0,8'h00,  0,0,1,32'h001000B3, 1,0,1,0,8'hB0));
        vt.push_back(v(0,1,0,0,8'h00,  0,0,1,32'h001000B3, 1,0,1,1,8'hB0));
        vt.push_back(v(0,1,5,0,8'h00,  0,0,1,32'h001000B3, 1,0,1,1,8'hB0));
        vt.push_back(v(0,0,0,1,8'h55,  0,0,1,32'h001000B3, 1,0,1,1,8'hB0));
        vt.push_back(v(1,1,1,1,8'h66,  0,0,0,32'h0,        0,0,0,0,8'h00));
        vt.push_back(v(0,1,0,0,8'h00,  0,0,0,32'h0,        0,0,0,1,8'h00));
        vt.push_back(v(0,1,5,0,8'h00,  0,0,0,32'h0,        0,0,0,1,8'h00));
        vt.push_back(v(0,0,0,1,8'h77,  0,0,0,32'h0,        0,0,0,1,8'h00));
        vt.push_back(v(0,1,7,0,8'h00,  0,0,0,32'h0,        0,0,0,1,8'h00));
        vt.push_back(v(0,1,1,0,8'h00,  1,0,0,32'h0,        0,1,0,0,8'h00));
        vt.push_back(v(1,0,0,0,8'h00,  0,0,0,32'h0,        0,0,0,0,8'h00));

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; start = vt[i].start; load_words = vt[i].lw;
            byte_valid = vt[i].bv; byte_data = vt[i].bd;
            tick();
            chk($sformatf("vec%0d", i),
                {16'd0, byte_ready, mem_we, mem_addr, mem_wdata, core_rst, busy, done, err, checksum},
                {16'd0, vt[i].br, vt[i].we, vt[i].addr, vt[i].wd, vt[i].cr, vt[i].busy,
                 vt[i].done, vt[i].err, vt[i].cs});
        end
        chk("table_writes", 64'(wlog.size()), 64'd2);

        // ---------------- stalled 2-word load ----------------
        bytes8[0] = 8'h13; bytes8[1] = 8'h00; bytes8[2] = 8'h00; bytes8[3] = 8'h00;
        bytes8[4] = 8'hB3; bytes8[5] = 8'h00; bytes8[6] = 8'h10; bytes8[7] = 8'h00;
        do_reset();
        wlog.delete();
        do_start(3'd2);
        for (int i = 0; i < 8; i++) send_byte(bytes8[i], 3);
        wait_done("stall_done");
        chk("stall_nwrites", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("stall_w0", 64'(wlog[0]), {30'd0, 2'd0, 32'h00000013});
            chk("stall_w1", 64'(wlog[1]), {30'd0, 2'd1, 32'h001000B3});
        end
        chk("stall_cs", {56'd0, checksum}, 64'hB0);
        chk("stall_crst", {63'd0, core_rst}, 64'd1);

        // ---------------- reset after 6 of 8 bytes ----------------
        do_reset();
        wlog.delete();
        do_start(3'd2);
        for (int i = 0; i < 6; i++) send_byte(bytes8[i], 0);
        rst = 1'b1;
        tick();
        chk("midrst_outs",
            {16'd0, byte_ready, mem_we, mem_addr, mem_wdata, core_rst, busy, done, err, checksum},
            64'd0);
        rst = 1'b0;
        repeat (4) tick();
        chk("midrst_nwrites", 64'(wlog.size()), 64'd1);
        wlog.delete();
        do_start(3'd1);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        wait_done("fresh_done");
        chk("fresh_nwrites", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) chk("fresh_w0", 64'(wlog[0]), {30'd0, 2'd0, 32'h44332211});
        chk("fresh_cs", {56'd0, checksum}, 64'h44);

        // ---------------- reload from DONE ----------------
        chk("reload_pre_crst", {63'd0, core_rst}, 64'd1);
        wlog.delete();
        do_start(3'd1);
        chk("reload_crst_low", {61'd0, core_rst, done, busy}, 64'b001);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
        wait_done("reload_done");
        chk("reload_nwrites", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) chk("reload_w0", 64'(wlog[0]), {30'd0, 2'd0, 32'hDEADBEEF});
        chk("reload_crst_high", {63'd0, core_rst}, 64'd1);
        chk("reload_cs", {56'd0, checksum}, 64'h22);

        // ---------------- full depth (4 words) ----------------
        do_reset();
        wlog.delete();
        do_start(3'd4);
        for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 0);
        wait_done("depth_done");
        chk("depth_nwrites", 64'(wlog.size()), 64'd4);
        if (wlog.size() == 4) begin
            chk("depth_w0", 64'(wlog[0]), {30'd0, 2'd0, 32'h04030201});
            chk("depth_w1", 64'(wlog[1]), {30'd0, 2'd1, 32'h08070605});
            chk("depth_w2", 64'(wlog[2]), {30'd0, 2'd2, 32'h0C0B0A09});
            chk("depth_w3", 64'(wlog[3]), {30'd0, 2'd3, 32'h100F0E0D});
        end
        chk("depth_cs", {56'd0, checksum}, 64'h10);
        chk("depth_addr_hold", {62'd0, mem_addr}, 64'd3);

        chk("crst_during_write", 64'(crst_during_write), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
